program_loader: RTL and testbench

//   Writer side of the CPU's external program-RAM write port. Receives a byte stream over a

---
 rtl/program_loader.sv | 108 ++++++++++
 tb/tb_program_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program loader: assembles DATA_W-bit instruction words from a byte stream,
// writes them to program-RAM rows 0..DEPTH-1, and verifies a trailing XOR
// checksum. The CPU is held in reset with its clock gated off until a load
// completes with a matching checksum.
module program_loader #(
  parameter int DATA_W = 11,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] RAM_Write_Data,
  output logic [ADDR_W-1:0] RAM_Write_Address,
  output logic              RAM_Write_Enable,
  output logic              PC_Enable,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LO, S_HI, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          lo_q;
  logic [7:0]          xor_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [ADDR_W:0]     wl_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic                accept;
  logic                last_word;

  assign accept    = in_valid & in_ready;
  assign last_word = (cnt_q == ADDR_W'(DEPTH - 1));

  // Next-state selection; start only matters in the idle/terminal states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LO;
      S_LO:    if (accept) state_d = S_HI;
      S_HI:    if (accept) state_d = S_WRITE;
      S_WRITE: state_d = last_word ? S_CSUM : S_LO;
      S_CSUM:  if (accept) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // State register plus word assembly, checksum accumulation and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      xor_q   <= '0;
      cnt_q   <= '0;
      wl_q    <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: if (start) begin
          cnt_q <= '0;
          xor_q <= '0;
          wl_q  <= '0;
        end
        S_LO: if (accept) begin
          lo_q  <= in_data;
          xor_q <= xor_q ^ in_data;
        end
        // Upper bits of the high byte do not fit in the word but still count
        // toward the checksum.
        S_HI: if (accept) begin
          wdata_q <= {in_data[DATA_W-9:0], lo_q};
          waddr_q <= cnt_q;
          xor_q   <= xor_q ^ in_data;
        end
        S_WRITE: begin
          wl_q <= wl_q + (ADDR_W+1)'(1);
          if (!last_word) cnt_q <= cnt_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Control outputs decode from the state register alone so they cannot glitch.
  assign in_ready          = (state_q == S_LO) || (state_q == S_HI) || (state_q == S_CSUM);
  assign RAM_Write_Enable  = (state_q == S_WRITE);
  assign PC_Enable         = (state_q == S_DONE);
  assign cpu_reset         = (state_q != S_DONE);
  assign busy              = (state_q == S_LO) || (state_q == S_HI) ||
                             (state_q == S_WRITE) || (state_q == S_CSUM);
  assign done              = (state_q == S_DONE);
  assign error             = (state_q == S_ERR);
  assign RAM_Write_Data    = wdata_q;
  assign RAM_Write_Address = waddr_q;
  assign words_loaded      = wl_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: byte-stream stimulus with random stalls,
// a queue of expected RAM writes built from the words being sent, and a shadow
// RAM filled from observed write strobes.
module tb_program_loader;
  localparam int DATA_W = 11;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam logic [15:0] MASK = 16'h07FF;

  logic              clk = 1'b0;
  logic              reset, start, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, RAM_Write_Enable, PC_Enable, cpu_reset, busy, done, error;
  logic [DATA_W-1:0] RAM_Write_Data;
  logic [ADDR_W-1:0] RAM_Write_Address;
  logic [ADDR_W:0]   words_loaded;

  program_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .RAM_Write_Data(RAM_Write_Data),
    .RAM_Write_Address(RAM_Write_Address), .RAM_Write_Enable(RAM_Write_Enable),
    .PC_Enable(PC_Enable), .cpu_reset(cpu_reset), .busy(busy), .done(done),
    .error(error), .words_loaded(words_loaded));

  always #5 clk = ~clk;

  typedef struct { int addr; logic [15:0] data; } wr_t;

  int           n_checks = 0;
  int           n_errors = 0;
  wr_t          exp_q[$];
  logic [15:0]  ram[DEPTH];
  logic [15:0]  wv[DEPTH];
  int           nstrobe = 0;
  logic [7:0]   last_csum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare: each strobe must match the next expected write, and
  // words_loaded must track the strobes seen since the current load started.
  always @(negedge clk) begin
    if (!reset) begin
      check("cpu_reset_vs_pc", {31'd0, cpu_reset}, {31'd0, ~PC_Enable});
      check("done_err_excl", {31'd0, done & error}, 32'd0);
      check("ready_implies_busy", {31'd0, in_ready & ~busy}, 32'd0);
      if (RAM_Write_Enable) begin
        check("we_not_ready", {31'd0, in_ready}, 32'd0);
        check("wl_during_write", 32'(words_loaded), 32'(nstrobe));
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(RAM_Write_Address), 32'(e.addr));
          check("wr_data", 32'(RAM_Write_Data), 32'(e.data));
        end
        ram[RAM_Write_Address] = 16'(RAM_Write_Data);
        nstrobe++;
      end else if (busy) begin
        check("wl_busy", 32'(words_loaded), 32'(nstrobe));
      end
    end
  end

  // Present one byte, dropping in_valid on roughly stall_pct% of cycles, and
  // return just after the edge on which it was accepted.
  task automatic send(input logic [7:0] b, input int stall_pct);
    bit acc = 0;
    int cyc = 0;
    in_data = b;
    while (!acc) begin
      logic rdy;
      in_valid = ($urandom_range(99) >= stall_pct);
      rdy = in_ready;
      @(posedge clk);
      #1;
      acc = in_valid && rdy;
      cyc++;
      if (cyc > 500) begin
        n_checks++; n_errors++;
        $display("FAIL send_timeout: byte 0x%0h never accepted", b);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "stream stuck");
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic begin_load();
    pulse_start();
    nstrobe = 0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_pc_off", {31'd0, PC_Enable}, 32'd0);
    check("start_wl_clr", 32'(words_loaded), 32'd0);
  endtask

  // Full load of wv[]. bad flips checksum bit 0; hi_start_idx pulses start
  // while that word's high byte is pending; abort_at resets after that many
  // words have been written.
  task automatic do_load(input int stall, input bit bad, input int hi_start_idx,
                         input int abort_at);
    logic [7:0] x = 8'h00;
    begin_load();
    for (int i = 0; i < DEPTH; i++) begin
      wr_t e;
      if (i == abort_at) begin
        @(posedge clk); #1;
        check("abort_strobes", 32'(nstrobe), 32'(abort_at));
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_wl", 32'(words_loaded), 32'd0);
        check("abort_we", {31'd0, RAM_Write_Enable}, 32'd0);
        check("abort_ready", {31'd0, in_ready}, 32'd0);
        check("abort_q_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_idle_busy", {31'd0, busy}, 32'd0);
        return;
      end
      e.addr = i;
      e.data = wv[i] & MASK;
      exp_q.push_back(e);
      send(wv[i][7:0], stall);
      x = x ^ wv[i][7:0];
      if (i == hi_start_idx) pulse_start();
      send(wv[i][15:8], stall);
      x = x ^ wv[i][15:8];
    end
    last_csum = x;
    send(bad ? (x ^ 8'h01) : x, stall);
    check("fin_done", {31'd0, done}, {31'd0, ~bad});
    check("fin_error", {31'd0, error}, {31'd0, bad});
    check("fin_pc", {31'd0, PC_Enable}, {31'd0, ~bad});
    check("fin_cpu_reset", {31'd0, cpu_reset}, {31'd0, bad});
    check("fin_busy", {31'd0, busy}, 32'd0);
    check("fin_wl", 32'(words_loaded), 32'(DEPTH));
    check("fin_q_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < DEPTH; i++) check("ram_row", 32'(ram[i]), 32'(wv[i] & MASK));
    repeat (3) @(posedge clk);
    #1;
    check("terminal_hold", {31'd0, done | error}, 32'd1);
  endtask

  task automatic t2_words();
    wv[0] = 16'h07FF; wv[1] = 16'h0001; wv[2] = 16'h0123; wv[3] = 16'h0456;
    wv[4] = 16'h0000; wv[5] = 16'h02AA; wv[6] = 16'h0555; wv[7] = 16'h00F0;
  endtask

  task automatic rand_words();
    for (int i = 0; i < DEPTH; i++) wv[i] = 16'($urandom);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    for (int i = 0; i < DEPTH; i++) ram[i] = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    // T1 reset values
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we", {31'd0, RAM_Write_Enable}, 32'd0);
    check("rst_pc", {31'd0, PC_Enable}, 32'd0);
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_wl", 32'(words_loaded), 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_wdata", 32'(RAM_Write_Data), 32'd0);
    check("rst_waddr", 32'(RAM_Write_Address), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // start must not move things forward until it is actually pulsed
    check("idle_busy", {31'd0, busy}, 32'd0);

    // T2 good load; checksum of the reference word list is 0x81
    t2_words();
    do_load(0, 1'b0, -1, -1);
    check("t2_csum_model", 32'(last_csum), 32'h81);
    // T3 back-pressure
    do_load(50, 1'b0, -1, -1);
    // T4 bad checksum, then recover with a good load
    do_load(30, 1'b1, -1, -1);
    do_load(0, 1'b0, -1, -1);
    // T5 reset after three writes, then a full load
    do_load(20, 1'b0, -1, 3);
    do_load(40, 1'b0, -1, -1);
    // T6 high byte with upper bits set, and start pulsed while in HI
    rand_words();
    wv[5] = 16'hFD34;
    do_load(10, 1'b0, 5, -1);
    check("t6_row5", 32'(ram[5]), 32'h534);
    // randomized loads
    for (int n = 0; n < 12; n++) begin
      rand_words();
      do_load(int'($urandom_range(70)), 1'($urandom_range(3) == 0), -1,
              ($urandom_range(4) == 0) ? int'($urandom_range(DEPTH - 1, 1)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
